pixel_wr_arbiter: RTL
=====================

PIXEL_WR_ARBITER -- requirements
Module: pixel_wr_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of pixel-buffer FIFO channels (1..8).
REQ-002 Parameter RAYID_W, default 19, rayID width; entry width EW = RAYID_W+24.
REQ-003 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-004 Parameter BASE_ADDR, default 0, frame base word address.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_b  input  1  reset, asynchronous, active-low.
REQ-007 pb_empty  input  NUM_CH  per-channel FIFO empty.
REQ-008 pb_data  input  NUM_CH*EW  show-ahead FIFO heads; channel i at bits [i*EW +: EW]; within an entry: rayID [EW-1:24], red [23:16], green [15:8], blue [7:0].
REQ-009 pb_re  output  NUM_CH  one-hot pop strobe, at most one bit high per cycle.
REQ-010 rd_req  input  1  display-side read request.
REQ-011 rd_addr  input  ADDR_W  display read word address.
REQ-012 rd_gnt  output  1  read serviced this cycle.
REQ-013 rd_data  output  16  registered read word.
REQ-014 rd_valid  output  1  rd_data valid pulse.
REQ-015 sram_addr  output  ADDR_W; sram_we, sram_re, sram_ub, sram_lb  output  1 each  active-high SRAM controls.
REQ-016 sram_io  inout  16  SRAM data; driven only while sram_we=1, else high-Z.
REQ-017 pix_cnt  output  32  pixels written (see Configuration).

Function
REQ-018 States: IDLE, WR_LO, WR_HI.
REQ-019 Read priority: whenever rd_req=1, rd_gnt=1, sram_re=1, sram_we=0, sram_addr=rd_addr, ub=lb=1, same cycle, in any state; the FSM holds state and latched entry.
REQ-020 rd_data SHALL capture sram_io at the edge ending a granted cycle; rd_valid=1 the following cycle only.
REQ-021 Selection: in IDLE (or WR_HI, see REQ-024) with rd_req=0 and any channel non-empty, choose the first non-empty channel at or after rr_ptr (modulo NUM_CH), pulse its pb_re, latch its entry, set rr_ptr = chosen+1 mod NUM_CH.
REQ-022 WR_LO (rd_req=0): sram_we=1, sram_addr = BASE_ADDR + 2*rayID, sram_io = {red,green}, ub=lb=1; next WR_HI.
REQ-023 WR_HI (rd_req=0): sram_we=1, sram_addr = BASE_ADDR + 2*rayID + 1, sram_io = {blue,8'h00}, ub=1, lb=0; pix_cnt increments.
REQ-024 From WR_HI with another channel non-empty: select per REQ-021 in the same cycle and go to WR_LO (2 cycles/pixel sustained); else go to IDLE.
REQ-025 Address arithmetic modulo 2^ADDR_W; overflow wraps silently.
REQ-026 pb_re never asserts for an empty channel nor in a cycle with rd_req=1.
REQ-027 Continuous rd_req stalls writes indefinitely; no entry is lost or reordered.
REQ-028 NUM_CH=1: round-robin degenerates to the single channel.

Reset
REQ-029 rst_b=0 asynchronously: state IDLE, rr_ptr=0, latched entry=0, rd_data=0, rd_valid=0, pix_cnt=0.
REQ-030 During reset pb_re=0, rd_gnt=0, sram_we=0, sram_re=0, ub=lb=0, sram_addr=0, sram_io high-Z.
REQ-031 Reset mid-write abandons the popped entry; no further SRAM write for it.

Configuration
REQ-032 Macro PIXWR_STATS_EN defined: pix_cnt is a 32-bit counter incremented per REQ-023, saturating at 32'hFFFF_FFFF.
REQ-033 Macro undefined: counter logic omitted, pix_cnt tied to 0; all other behaviour identical.

Verification
REQ-034 Ch0 entry rayID=1, RGB=12/34/56 -> write addr 2 data 16'h1234 ub=lb=1, then addr 3 data 16'h5600 ub=1 lb=0; pix_cnt=1.
REQ-035 Ch0 rayID=1 RGB=12/34/56, ch0 next rayID=0 RGB=78/9A/BC back-to-back -> four consecutive write cycles addr 2,3,0,1, no IDLE gap.
REQ-036 All 4 channels non-empty from reset -> pops in order ch0,ch1,ch2,ch3,ch0; each pb_re one-hot.
REQ-037 rd_req=1 rd_addr=20'h00010 in WR_LO -> rd_gnt same cycle, no write; write resumes next cycle unchanged; rd_valid one cycle later with SRAM word.
REQ-038 BASE_ADDR=20'hFFFFE, rayID=1 -> writes at 20'h00000 and 20'h00001 (wrap); rst_b low in WR_HI -> no further write, outputs per REQ-030.

Source files
------------

// File: rtl/pixel_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_wr_arbiter
// Description : Round-robin drain of NUM_CH pixel FIFOs into a 16-bit SRAM,
//               two write cycles per pixel, display reads take priority.
//               Optional macro PIXWR_STATS_EN enables the pix_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_wr_arbiter #(
    parameter int                NUM_CH    = 4,
    parameter int                RAYID_W   = 19,
    parameter int                ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic [NUM_CH-1:0]              pb_empty,
    input  logic [NUM_CH*(RAYID_W+24)-1:0] pb_data,
    output logic [NUM_CH-1:0]              pb_re,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_gnt,
    output logic [15:0]                    rd_data,
    output logic                           rd_valid,
    output logic [ADDR_W-1:0]              sram_addr,
    output logic                           sram_we,
    output logic                           sram_re,
    output logic                           sram_ub,
    output logic                           sram_lb,
    inout  wire  [15:0]                    sram_io,
    output logic [31:0]                    pix_cnt
);

    localparam int c_EW    = RAYID_W + 24;
    localparam int c_PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WR_LO = 2'd1;
    localparam logic [1:0] c_WR_HI = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_EW-1:0]    r_entry;
    logic [15:0]        r_rd_data;
    logic               r_rd_valid;

    logic               w_any;
    logic               w_hi_any;
    logic [c_PTR_W-1:0] w_lo_idx;
    logic [c_PTR_W-1:0] w_hi_idx;
    logic [c_PTR_W-1:0] w_sel_idx;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic [c_EW-1:0]    w_sel_entry;
    logic               w_load;
    logic [15:0]        w_wdata;
    logic [ADDR_W-1:0]  w_wr_addr_lo;

    // Lowest non-empty channel at/after the pointer wins, else lowest overall.
    always_comb begin
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_lo_idx = '0;
        w_hi_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!pb_empty[i]) begin
                w_any    = 1'b1;
                w_lo_idx = c_PTR_W'(i);
                if (c_PTR_W'(i) >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = c_PTR_W'(i);
                end
            end
        end
        w_sel_idx   = w_hi_any ? w_hi_idx : w_lo_idx;
        w_next_ptr  = (w_sel_idx == c_PTR_W'(NUM_CH - 1)) ? '0 : w_sel_idx + 1'b1;
        w_sel_entry = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sel_idx == c_PTR_W'(i)) begin
                w_sel_entry = pb_data[i*c_EW +: c_EW];
            end
        end
    end

    assign w_wr_addr_lo = BASE_ADDR + ADDR_W'({r_entry[c_EW-1:24], 1'b0});

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_wdata      = 16'h0000;
        pb_re        = '0;
        rd_gnt       = 1'b0;
        sram_we      = 1'b0;
        sram_re      = 1'b0;
        sram_ub      = 1'b0;
        sram_lb      = 1'b0;
        sram_addr    = '0;
        // Outputs are forced quiet while reset is asserted, whatever the inputs.
        if (rst_b) begin
            if (rd_req) begin
                rd_gnt    = 1'b1;
                sram_re   = 1'b1;
                sram_ub   = 1'b1;
                sram_lb   = 1'b1;
                sram_addr = rd_addr;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_any) begin
                            w_load       = 1'b1;
                            w_next_state = c_WR_LO;
                        end
                    end
                    c_WR_LO: begin
                        sram_we      = 1'b1;
                        sram_ub      = 1'b1;
                        sram_lb      = 1'b1;
                        sram_addr    = w_wr_addr_lo;
                        w_wdata      = r_entry[23:8];
                        w_next_state = c_WR_HI;
                    end
                    c_WR_HI: begin
                        sram_we      = 1'b1;
                        sram_ub      = 1'b1;
                        sram_addr    = w_wr_addr_lo + ADDR_W'(1);
                        w_wdata      = {r_entry[7:0], 8'h00};
                        w_load       = w_any;
                        w_next_state = w_any ? c_WR_LO : c_IDLE;
                    end
                    default: w_next_state = c_IDLE;
                endcase
                for (int i = 0; i < NUM_CH; i++) begin
                    pb_re[i] = w_load && (w_sel_idx == c_PTR_W'(i));
                end
            end
        end
    end

    assign sram_io = sram_we ? w_wdata : 16'hzzzz;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= '0;
            r_entry    <= '0;
            r_rd_data  <= 16'h0000;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rd_valid <= rd_gnt;
            if (w_load) begin
                r_entry  <= w_sel_entry;
                r_rr_ptr <= w_next_ptr;
            end
            if (rd_gnt) begin
                r_rd_data <= sram_io;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

`ifdef PIXWR_STATS_EN
    logic [31:0] r_pix_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pix_cnt <= 32'h0;
        end else if (!rd_req && (r_state == c_WR_HI) && (r_pix_cnt != 32'hFFFF_FFFF)) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
        end
    end

    assign pix_cnt = r_pix_cnt;
`else
    assign pix_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
